// File: rtl/cfu_cmd_queue.sv
// cfu_cmd_queue: in-order command FIFO between the CPU command port and the CFU core.
// Define CFU_CMDQ_BYPASS_EN to let a command pass straight through an empty queue with zero latency.

module cfu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,

    input  logic                     s_cmd_valid,
    output logic                     s_cmd_ready,
    input  logic [9:0]               s_cmd_payload_function_id,
    input  logic [31:0]              s_cmd_payload_inputs_0,
    input  logic [31:0]              s_cmd_payload_inputs_1,

    output logic                     m_cmd_valid,
    input  logic                     m_cmd_ready,
    output logic [9:0]               m_cmd_payload_function_id,
    output logic [31:0]              m_cmd_payload_inputs_0,
    output logic [31:0]              m_cmd_payload_inputs_1,

    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [9:0]  function_id;
        logic [31:0] inputs_0;
        logic [31:0] inputs_1;
    } cmd_t;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    cmd_t          mem_q [DEPTH];

    cmd_t s_entry;
    cmd_t head_entry;
    cmd_t out_entry;
    logic empty;
    logic full;
    logic push;
    logic wr_en;
    logic rd_en;

    assign s_entry    = {s_cmd_payload_function_id, s_cmd_payload_inputs_0, s_cmd_payload_inputs_1};
    assign head_entry = mem_q[rd_ptr_q];

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // Ready depends only on state and flush, never on m_cmd_ready: no ready->ready path.
    assign s_cmd_ready = ~full & ~flush;
    assign push        = s_cmd_valid & s_cmd_ready;
    assign rd_en       = ~empty & m_cmd_ready;

`ifdef CFU_CMDQ_BYPASS_EN
    logic bypass;

    assign bypass      = empty & s_cmd_valid & ~flush;
    assign m_cmd_valid = ~empty | bypass;
    assign out_entry   = bypass ? s_entry : head_entry;
    // A bypassed command the core takes in the same cycle never touches the array.
    assign wr_en       = push & ~(bypass & m_cmd_ready);
`else
    assign m_cmd_valid = ~empty;
    assign out_entry   = head_entry;
    assign wr_en       = push;
`endif

    assign m_cmd_payload_function_id = out_entry.function_id;
    assign m_cmd_payload_inputs_0    = out_entry.inputs_0;
    assign m_cmd_payload_inputs_1    = out_entry.inputs_1;
    assign level                     = count_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the array is deliberately not reset; count gates its visibility, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s_entry;
        end
    end

endmodule

// File: tb/tb_cfu_cmd_queue.sv
// Directed self-checking bench for cfu_cmd_queue (DEPTH = 4); follows CFU_CMDQ_BYPASS_EN if defined.

module tb_cfu_cmd_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [9:0]  s_fid;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic        m_cmd_valid;
    logic        m_cmd_ready;
    logic [9:0]  m_fid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    cfu_cmd_queue #(.DEPTH(4)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .flush                     (flush),
        .s_cmd_valid               (s_cmd_valid),
        .s_cmd_ready               (s_cmd_ready),
        .s_cmd_payload_function_id (s_fid),
        .s_cmd_payload_inputs_0    (s_a),
        .s_cmd_payload_inputs_1    (s_b),
        .m_cmd_valid               (m_cmd_valid),
        .m_cmd_ready               (m_cmd_ready),
        .m_cmd_payload_function_id (m_fid),
        .m_cmd_payload_inputs_0    (m_a),
        .m_cmd_payload_inputs_1    (m_b),
        .level                     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stand-in for the CFU core: 0 = add, 1 = subtract, 2 = multiply.
    function automatic logic [31:0] core_result(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
        case (fid)
            10'd0:   return a + b;
            10'd1:   return a - b;
            10'd2:   return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // Advance to just after the next rising edge; inputs are driven and outputs sampled from here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
        s_cmd_valid = 1'b1;
        s_fid = fid;
        s_a = a;
        s_b = b;
        tick();
        s_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (s_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_cmd_ready); end
        checks++; if (m_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_cmd_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    endtask

    task automatic test_latency();
        m_cmd_ready = 1'b1;
        s_cmd_valid = 1'b1;
        s_fid = 10'd2;
        s_a = 32'd6;
        s_b = 32'd7;
        #1;
`ifdef CFU_CMDQ_BYPASS_EN
        checks++; if (m_cmd_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b expected 1", m_cmd_valid); end
        checks++; if (m_fid !== 10'd2) begin errors++; $display("FAIL bypass_fid: got %0d expected 2", m_fid); end
        checks++; if (m_a !== 32'd6 || m_b !== 32'd7) begin errors++; $display("FAIL bypass_operands: got %0d,%0d expected 6,7", m_a, m_b); end
        tick();
        s_cmd_valid = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL bypass_level: got %0d expected 0", level); end
        checks++; if (m_cmd_valid !== 1'b0) begin errors++; $display("FAIL bypass_after_valid: got %b expected 0", m_cmd_valid); end
        // Flush must also block the bypass path.
        flush = 1'b1;
        s_cmd_valid = 1'b1;
        #1;
        checks++; if (m_cmd_valid !== 1'b0) begin errors++; $display("FAIL bypass_flush_valid: got %b expected 0", m_cmd_valid); end
        checks++; if (s_cmd_ready !== 1'b0) begin errors++; $display("FAIL bypass_flush_ready: got %b expected 0", s_cmd_ready); end
        tick();
        flush = 1'b0;
        s_cmd_valid = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL bypass_flush_level: got %0d expected 0", level); end
`else
        checks++; if (m_cmd_valid !== 1'b0) begin errors++; $display("FAIL latency_same_cycle: got %b expected 0", m_cmd_valid); end
        tick();
        s_cmd_valid = 1'b0;
        #1;
        checks++; if (m_cmd_valid !== 1'b1) begin errors++; $display("FAIL latency_next_cycle: got %b expected 1", m_cmd_valid); end
        checks++; if (core_result(m_fid, m_a, m_b) !== 32'd42) begin errors++; $display("FAIL latency_result: got %0d expected 42", core_result(m_fid, m_a, m_b)); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL latency_level: got %0d expected 1", level); end
        tick();
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL latency_drain: got %0d expected 0", level); end
`endif
        m_cmd_ready = 1'b0;
    endtask

    task automatic test_in_order();
        logic [9:0]  fids [3] = '{10'd0, 10'd1, 10'd2};
        logic [31:0] as   [3] = '{32'd5, 32'd9, 32'd3};
        logic [31:0] bs   [3] = '{32'd7, 32'd4, 32'd6};
        logic [31:0] exp  [3] = '{32'd12, 32'd5, 32'd18};
        m_cmd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_cmd(fids[k], as[k], bs[k]);
        end
        #1;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL in_order_level: got %0d expected 3", level); end
        m_cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (m_cmd_valid !== 1'b1) begin errors++; $display("FAIL in_order_valid_%0d: got %b expected 1", k, m_cmd_valid); end
            checks++; if (m_fid !== fids[k]) begin errors++; $display("FAIL in_order_fid_%0d: got %0d expected %0d", k, m_fid, fids[k]); end
            checks++; if (core_result(m_fid, m_a, m_b) !== exp[k]) begin errors++; $display("FAIL in_order_result_%0d: got %0d expected %0d", k, core_result(m_fid, m_a, m_b), exp[k]); end
            tick();
        end
        m_cmd_ready = 1'b0;
        #1;
        checks++; if (level !== 3'd0 || m_cmd_valid !== 1'b0) begin errors++; $display("FAIL in_order_empty: got level %0d valid %b expected 0 0", level, m_cmd_valid); end
    endtask

    task automatic test_full();
        m_cmd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_cmd(10'(k), 32'(10 + k), 32'd1);
        end
        #1;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d expected 4", level); end
        checks++; if (s_cmd_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %b expected 0", s_cmd_ready); end
        s_cmd_valid = 1'b1;
        s_fid = 10'd4;
        s_a = 32'd14;
        s_b = 32'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (s_cmd_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready_%0d: got %b expected 0", c, s_cmd_ready); end
            tick();
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_hold_level: got %0d expected 4", level); end
        m_cmd_ready = 1'b1;
        #1;
        checks++; if (s_cmd_ready !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle_ready: got %b expected 0", s_cmd_ready); end
        checks++; if (m_fid !== 10'd0) begin errors++; $display("FAIL full_head_fid: got %0d expected 0", m_fid); end
        tick();
        m_cmd_ready = 1'b0;
        #1;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_after_pop_level: got %0d expected 3", level); end
        checks++; if (s_cmd_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready: got %b expected 1", s_cmd_ready); end
        tick();
        s_cmd_valid = 1'b0;
        #1;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_fifth_accepted: got %0d expected 4", level); end
        m_cmd_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            #1;
            checks++; if (m_cmd_valid !== 1'b1 || m_fid !== 10'(k) || m_a !== 32'(10 + k)) begin
                errors++; $display("FAIL full_drain_%0d: got valid %b fid %0d a %0d expected 1 %0d %0d", k, m_cmd_valid, m_fid, m_a, k, 10 + k);
            end
            tick();
        end
        m_cmd_ready = 1'b0;
        #1;
        checks++; if (level !== 3'd0 || m_cmd_valid !== 1'b0) begin errors++; $display("FAIL full_drain_empty: got level %0d valid %b expected 0 0", level, m_cmd_valid); end
    endtask

    task automatic test_back_to_back();
        m_cmd_ready = 1'b1;
        s_fid = 10'd0;
        for (int i = 0; i <= 10; i++) begin
            s_cmd_valid = (i < 10);
            s_a = 32'(i);
            s_b = 32'(i);
            #1;
`ifdef CFU_CMDQ_BYPASS_EN
            if (i < 10) begin
                checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_level_%0d: got %0d expected 0", i, level); end
                checks++; if (m_cmd_valid !== 1'b1 || core_result(m_fid, m_a, m_b) !== 32'(2 * i)) begin
                    errors++; $display("FAIL b2b_out_%0d: got valid %b result %0d expected 1 %0d", i, m_cmd_valid, core_result(m_fid, m_a, m_b), 2 * i);
                end
            end
`else
            if (i > 0) begin
                checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level_%0d: got %0d expected 1", i, level); end
                checks++; if (m_cmd_valid !== 1'b1 || core_result(m_fid, m_a, m_b) !== 32'(2 * (i - 1))) begin
                    errors++; $display("FAIL b2b_out_%0d: got valid %b result %0d expected 1 %0d", i, m_cmd_valid, core_result(m_fid, m_a, m_b), 2 * (i - 1));
                end
            end
`endif
            tick();
        end
        s_cmd_valid = 1'b0;
        m_cmd_ready = 1'b0;
        #1;
        checks++; if (level !== 3'd0 || m_cmd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got level %0d valid %b expected 0 0", level, m_cmd_valid); end
    endtask

    task automatic test_flush();
        m_cmd_ready = 1'b0;
        push_cmd(10'd5, 32'd1, 32'd1);
        push_cmd(10'd6, 32'd2, 32'd2);
        flush = 1'b1;
        s_cmd_valid = 1'b1;
        s_fid = 10'd7;
        s_a = 32'd3;
        s_b = 32'd3;
        #1;
        checks++; if (s_cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_s_ready: got %b expected 0", s_cmd_ready); end
        tick();
        flush = 1'b0;
        s_cmd_valid = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", level); end
        checks++; if (m_cmd_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid: got %b expected 0", m_cmd_valid); end
        push_cmd(10'd8, 32'd4, 32'd4);
        #1;
        checks++; if (level !== 3'd1 || m_fid !== 10'd8) begin errors++; $display("FAIL flush_reuse: got level %0d fid %0d expected 1 8", level, m_fid); end
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_cmd_ready = 1'b0;
        push_cmd(10'd0, 32'd1, 32'd2);
        push_cmd(10'd1, 32'd3, 32'd4);
        push_cmd(10'd2, 32'd5, 32'd6);
        #1;
        checks++; if (level !== 3'd3 || m_cmd_valid !== 1'b1) begin errors++; $display("FAIL reset_mid_pre: got level %0d valid %b expected 3 1", level, m_cmd_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_mid_level: got %0d expected 0", level); end
        checks++; if (m_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_m_valid: got %b expected 0", m_cmd_valid); end
        checks++; if (s_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_s_ready: got %b expected 1", s_cmd_ready); end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        s_cmd_valid = 1'b0;
        s_fid = '0;
        s_a = '0;
        s_b = '0;
        m_cmd_ready = 1'b0;

        test_reset();
        test_latency();
        test_in_order();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfu_cmd_queue.md
Name: cfu_cmd_queue

Overview:
- Command FIFO between the CPU command port and the CFU core's cmd_valid/cmd_ready input.
- Lets the CPU post back-to-back commands while the core is still holding a response (core cmd_ready low).
- Entry = {function_id[9:0], inputs_0[31:0], inputs_1[31:0]} = 74 bits.
- Strict in-order delivery; no reordering, no modification of payload.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all queued entries.
- s_cmd_valid  input  1  CPU-side command valid.
- s_cmd_ready  output  1  CPU-side ready; = ~full & ~flush.
- s_cmd_payload_function_id  input  10  CPU function id.
- s_cmd_payload_inputs_0  input  32  CPU operand 0.
- s_cmd_payload_inputs_1  input  32  CPU operand 1.
- m_cmd_valid  output  1  core-side valid; = ~empty.
- m_cmd_ready  input  1  core-side ready (core's cmd_ready).
- m_cmd_payload_function_id  output  10  head entry function id.
- m_cmd_payload_inputs_0  output  32  head entry operand 0.
- m_cmd_payload_inputs_1  output  32  head entry operand 1.
- level  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 74 register array; wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH; count is AW+1 bits.
- Push: s_cmd_valid & s_cmd_ready at a clock edge writes mem[wr_ptr] and increments wr_ptr.
- Pop: m_cmd_valid & m_cmd_ready at a clock edge increments rd_ptr.
- Payload outputs are driven from mem[rd_ptr] (combinational read of a registered array). Values are don't-care while empty; the bench must not check them.
- Latency: a push at edge N makes m_cmd_valid high after edge N, i.e. one cycle.
- empty = (count == 0); full = (count == DEPTH); level = count.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: s_cmd_ready = 0 even when m_cmd_ready = 1 in the same cycle. No push-through-pop when full, so there is no ready->ready combinational path.
- Empty: m_cmd_valid = 0, and m_cmd_ready is ignored.
- Pointer wrap: DEPTH-1 -> 0. Ordering is preserved across the wrap.
- Flush:
  - Next edge sets wr_ptr = rd_ptr = 0 and count = 0.
  - s_cmd_ready is low during flush, so no push is accepted.
  - A pop in the same cycle is harmless because the queue is cleared regardless.
- Reset: same effect as flush and overrides everything. After reset: s_cmd_ready = 1, m_cmd_valid = 0, level = 0. Array contents are not reset.
- Reset mid-operation: all queued commands are lost. The CPU-side handshake is not retried by this block.
- Outputs are never X after reset, except the payload outputs while empty.

Optional Feature:
- Macro: CFU_CMDQ_BYPASS_EN.
- Defined:
  - When empty and s_cmd_valid = 1, m_cmd_valid = 1 in the same cycle, with the m payload taken directly from the s payload (zero latency).
  - If m_cmd_ready = 1 in that cycle, the command is consumed without being written and count stays 0.
  - If m_cmd_ready = 0, the command is written normally and is presented from the array the next cycle.
  - flush still forces s_cmd_ready = 0 and m_cmd_valid = 0 for the bypass path.
- Undefined: strictly registered path with 1-cycle latency as above, and no s->m combinational path.

Test Plan:
- Reset, then push 3 commands {fid=0,a=5,b=7}, {fid=1,a=9,b=4}, {fid=2,a=3,b=6} with m_cmd_ready = 0 -> level = 3, then release m_cmd_ready -> payloads appear in that order; core outputs 12, 5, 18.
- Fill DEPTH = 4 with m_cmd_ready = 0 -> s_cmd_ready = 0 and level = 4. A 5th s_cmd_valid held for 3 cycles is not accepted. Pop one -> s_cmd_ready = 1 on the next cycle and the 5th entry is accepted.
- Continuous push and pop for 10 commands with fid=0, a=i, b=i -> level stays at 1, pointers wrap twice, outputs match in order 0, 2, 4, ..., 18.
- Queue holding 2 entries, assert flush for 1 cycle while s_cmd_valid = 1 -> s_cmd_ready = 0, next cycle level = 0 and m_cmd_valid = 0, and the offered command is not stored.
- Reset asserted with level = 3 -> next cycle level = 0, m_cmd_valid = 0, s_cmd_ready = 1.
- CFU_CMDQ_BYPASS_EN with queue empty, s_cmd_valid = 1, fid=2, a=6, b=7, m_cmd_ready = 1 -> m_cmd_valid = 1 in the same cycle, payload passes through, and level stays 0. Without the macro -> m_cmd_valid rises one cycle later.
